idct_2d_mac: RTL and testbench



---
 rtl/idct_2d_mac_if.sv | 12 +
 rtl/idct_2d_mac.sv | 105 ++++++++++
 tb/tb_idct_2d_mac.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/idct_2d_mac_if.sv
// idct_2d_mac_if: coefficient/pixel handshake between dequantizer, IDCT and pixel writer.
interface idct_2d_mac_if #(
    parameter int COEF_W = 12
);
    logic                  start;
    logic [64*COEF_W-1:0]  coef_data;
    logic                  busy;
    logic                  done;
    logic [511:0]          pix_out;
    modport master (output start, coef_data, input busy, done, pix_out);
    modport slave (input start, coef_data, output busy, done, pix_out);
endinterface

// File: rtl/idct_2d_mac.sv
// idct_2d_mac: 8x8 separable 2D inverse DCT on one time-shared MAC, row pass then column pass.
module idct_2d_mac #(
    parameter int COEF_W = 12,
    parameter int ROW_W  = 16,
    parameter int FRAC   = 12
) (
    input logic          clock,
    input logic          reset,
    idct_2d_mac_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_t;
    localparam logic signed [13:0] COS [9] = '{14'sd2048, 14'sd2009, 14'sd1892, 14'sd1703,
                                               14'sd1448, 14'sd1138, 14'sd784, 14'sd400, 14'sd0};
    localparam logic signed [31:0] RMAX = 2**(ROW_W-1) - 1;
    localparam logic signed [31:0] RMIN = -(2**(ROW_W-1));
    state_t state;
    logic [10:0] cnt;
    logic signed [COEF_W-1:0] coef [64];
    logic signed [ROW_W-1:0] rbuf [64];
    logic [511:0] obuf, obuf_nxt;
    logic signed [13:0] k;
    logic signed [ROW_W-1:0] a, r_sat;
    logic signed [31:0] prod, acc, sum, rnd, pv;
    logic [7:0] pix;
    logic p_vld, p_first, p_last, p_col;
    logic [5:0] p_idx;
    // cos((2x+1)u*pi/16) folded onto the first quadrant; the 5-bit angle wraps at 2*pi
    function automatic logic signed [13:0] rom(input logic [2:0] u, input logic [2:0] x);
        logic [4:0] m, f, g;
        logic signed [13:0] c;
        m = 5'(7'({x, 1'b1}) * 7'(u));
        f = m > 5'd16 ? 5'd0 - m : m;
        g = f > 5'd8 ? 5'd16 - f : f;
        c = COS[g[3:0]];
        return u == 3'd0 ? 14'sd1448 : f > 5'd8 ? -c : c;
    endfunction
    // Both passes use tap = cnt[2:0] and the output-position bits cnt[5:3] as ROM row/column
    always_comb begin
        k = rom(cnt[2:0], cnt[5:3]);
        a = state == ROW ? ROW_W'(coef[{cnt[8:6], cnt[2:0]}]) : rbuf[{cnt[2:0], cnt[8:6]}];
        sum = (p_first ? 32'sd0 : acc) + prod;
        rnd = (sum + (32'sd1 <<< (FRAC - 1))) >>> FRAC;
        r_sat = rnd > RMAX ? ROW_W'(RMAX) : rnd < RMIN ? ROW_W'(RMIN) : rnd[ROW_W-1:0];
        pv = rnd + 32'sd128;
        pix = pv < 32'sd0 ? 8'd0 : pv > 32'sd255 ? 8'd255 : pv[7:0];
        obuf_nxt = obuf;
        if (p_vld && p_col && p_last)
            obuf_nxt[{p_idx, 3'b000} +: 8] = pix;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 11'd0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.pix_out <= '0;
            obuf <= '0;
            acc <= '0;
            prod <= '0;
            p_vld <= 1'b0;
            p_first <= 1'b0;
            p_last <= 1'b0;
            p_col <= 1'b0;
            p_idx <= '0;
        end else begin
            p_vld <= state == ROW || (state == COL && cnt != 11'd1024);
            p_first <= cnt[2:0] == 3'd0;
            p_last <= cnt[2:0] == 3'd7;
            p_col <= state == COL;
            p_idx <= state == ROW ? cnt[8:3] : {cnt[5:3], cnt[8:6]};
            prod <= 32'(a) * 32'(k);
            if (p_vld)
                acc <= sum;
            if (p_vld && !p_col && p_last)
                rbuf[p_idx] <= r_sat;
            obuf <= obuf_nxt;
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    state <= bus.start ? ROW : IDLE;
                    bus.busy <= bus.start;
                    cnt <= 11'd0;
                    if (bus.start)
                        for (int i = 0; i < 64; i++)
                            coef[i] <= bus.coef_data[i*COEF_W +: COEF_W];
                end
                ROW: begin
                    cnt <= cnt + 11'd1;
                    if (cnt == 11'd511)
                        state <= COL;
                end
                default: begin
                    // one extra cycle drains the last column tap out of the MAC pipeline
                    cnt <= cnt + 11'd1;
                    if (cnt == 11'd1024) begin
                        state <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pix_out <= obuf_nxt;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_idct_2d_mac.sv
// tb_idct_2d_mac: scoreboard bench for idct_2d_mac; directed DC blocks plus model-checked random blocks.
module tb_idct_2d_mac;
    typedef struct {
        logic [511:0] pix;
        int           t;
    } exp_t;
    logic clock = 1'b0;
    logic reset;
    idct_2d_mac_if #(.COEF_W(12)) bus ();
    idct_2d_mac dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int run = 0;
    int kt [8][8];
    logic rst_q = 1'b0;
    logic [511:0] cur_exp = '0;
    logic [511:0] prev;
    exp_t sbq [$];
    exp_t mon_e;
    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask
    function automatic logic [511:0] model(input logic [767:0] c);
        longint r [64];
        longint s;
        logic [511:0] o;
        o = '0;
        for (int v = 0; v < 8; v++)
            for (int x = 0; x < 8; x++) begin
                s = 0;
                for (int u = 0; u < 8; u++) begin
                    logic signed [11:0] f;
                    f = c[(v*8+u)*12 +: 12];
                    s += longint'(f) * longint'(kt[u][x]);
                end
                s = (s + 2048) >>> 12;
                r[v*8+x] = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
            end
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                s = 0;
                for (int v = 0; v < 8; v++)
                    s += longint'(kt[v][y]) * r[v*8+x];
                s = ((s + 2048) >>> 12) + 128;
                o[(y*8+x)*8 +: 8] = s < 0 ? 8'd0 : s > 255 ? 8'd255 : 8'(s);
            end
        return o;
    endfunction
    function automatic logic [767:0] dc(input int v);
        logic [767:0] c;
        c = '0;
        c[11:0] = v[11:0];
        return c;
    endfunction
    function automatic logic [767:0] rand_block();
        logic [767:0] c;
        int t;
        for (int i = 0; i < 64; i++) begin
            t = int'($urandom_range(2047)) - 1024;
            c[i*12 +: 12] = t[11:0];
        end
        return c;
    endfunction
    // Acceptance is judged from the interface alone: start while not busy and not in reset
    always @(posedge clock) begin
        rst_q = reset;
        if (reset)
            sbq.delete();
        else if (bus.start && !bus.busy)
            sbq.push_back('{cur_exp, cyc});
        cyc++;
    end
    always @(negedge clock) begin
        if (rst_q) begin
            run = 0;
            prev = bus.pix_out;
        end else begin
            if (bus.busy)
                run++;
            if (bus.done) begin
                chk("busy_len", run, 1025);
                run = 0;
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending block");
                end else begin
                    mon_e = sbq.pop_front();
                    chk("pixels", bus.pix_out, mon_e.pix);
                    chk("latency", cyc - mon_e.t, 1026);
                end
                prev = bus.pix_out;
            end else
                chk("pix_stable", bus.pix_out, prev);
        end
    end
    task automatic wait_done();
        int i = 0;
        do begin
            @(negedge clock);
            i++;
        end while (!bus.done && i < 1100);
        if (!bus.done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", i);
        end
    endtask
    task automatic run_block(input logic [767:0] c, input logic [511:0] e);
        @(negedge clock);
        bus.coef_data = c;
        cur_exp = e;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        bus.coef_data = {24{$urandom}};
        wait_done();
    endtask
    initial begin
        logic [767:0] c;
        for (int u = 0; u < 8; u++)
            for (int x = 0; x < 8; x++)
                kt[u][x] = int'(4096.0 * (u == 0 ? 0.7071067811865476 : 1.0) / 2.0
                                * $cos((2*x+1) * u * 3.141592653589793 / 16.0));
        bus.start = 1'b0;
        bus.coef_data = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_pix", bus.pix_out, 0);
        reset = 1'b0;
        run_block('0, {64{8'd128}});
        run_block(dc(64), {64{8'd136}});
        run_block(dc(-1024), {64{8'd0}});
        run_block(dc(1016), {64{8'd255}});
        run_block(dc(2000), {64{8'd255}});
        run_block(dc(-2048), {64{8'd0}});
        for (int i = 0; i < 20; i++) begin
            c = rand_block();
            run_block(c, model(c));
        end
        // abort a block with reset; nothing may complete afterwards
        c = rand_block();
        @(negedge clock);
        bus.coef_data = c;
        cur_exp = model(c);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (600) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_pix", bus.pix_out, 0);
        reset = 1'b0;
        repeat (1100) @(negedge clock);
        c = rand_block();
        run_block(c, model(c));
        // start held high: back-to-back blocks with no bubble
        c = rand_block();
        @(negedge clock);
        bus.coef_data = c;
        cur_exp = model(c);
        bus.start = 1'b1;
        repeat (3) wait_done();
        bus.start = 1'b0;
        // start pulses during a busy block must be dropped
        c = rand_block();
        @(negedge clock);
        bus.coef_data = c;
        cur_exp = model(c);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (300) @(negedge clock);
        c = rand_block();
        bus.coef_data = c;
        cur_exp = model(c);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (600) @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done();
        repeat (1100) @(negedge clock);
        chk("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
